alu_cc_sequencer: RTL and testbench
===================================

ALU_CC_SEQUENCER -- requirements
Module: alu_cc_sequencer

Interface
REQ-001 The block SHALL have parameter CHUNK_W, default 16, giving the adder slice width in bits; legal values are 8, 16, 32 and 64; N = 64/CHUNK_W.
REQ-002 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-003 Ports SHALL be as follows (name, direction, width, meaning):
- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operation request.
- in_ready  out  1  block can accept an operation.
- ifun  in  4  Y86 OPq function: 0 addq, 1 subq, 2 andq, 3 xorq.
- val_a  in  64  operand valA.
- val_b  in  64  operand valB.
- set_cc  in  1  update condition codes on completion.
- out_valid  out  1  result available.
- out_ready  in  1  consumer takes the result.
- val_e  out  64  result valE.
- cc  out  3  condition codes: [2] ZF, [1] SF, [0] OF.
- err  out  1  the completed operation had an illegal ifun.
- busy  out  1  block is in CALC or DONE.

Function
REQ-004 The FSM SHALL have three states: IDLE, CALC and DONE; in_ready=1 only in IDLE; out_valid=1 only in DONE; busy = !IDLE.
REQ-005 In IDLE, in_valid&&in_ready SHALL latch ifun, val_a, val_b and set_cc, clear the chunk counter, carry and zero-accumulator, and move to CALC (legal ifun) or DONE (ifun>3).
REQ-006 In CALC, chunk k (bits k*CHUNK_W+CHUNK_W-1 : k*CHUNK_W, lowest first) SHALL be processed in cycle k, k=0..N-1, through a single shared CHUNK_W-bit adder.
REQ-007 addq SHALL compute val_b+val_a; subq SHALL compute val_b+~val_a with carry-in 1 at chunk 0; the carry-out of each chunk SHALL be registered and used as the carry-in of the next chunk; the final carry SHALL be discarded (mod 2^64).
REQ-008 andq and xorq SHALL compute val_b&val_a and val_b^val_a per chunk, ignoring the carry.
REQ-009 After chunk N-1 the FSM SHALL enter DONE, so out_valid rises exactly N cycles after the accepting edge (4 cycles at the default).
REQ-010 Flags SHALL be computed on the full 64-bit result t:
- ZF = (t==0), accumulated as an OR across chunks.
- SF = t[63].
- OF for addq = (a63==b63)&&(t63!=a63).
- OF for subq = (a63!=b63)&&(t63!=b63).
- OF = 0 for andq and xorq.
REQ-011 cc SHALL be written on the edge entering DONE only if the latched set_cc=1 and ifun is legal; otherwise cc SHALL hold its value.
REQ-012 For an illegal ifun: val_e=0, err=1 and cc unchanged, with out_valid one cycle after acceptance.
REQ-013 val_e and err SHALL be stable throughout DONE; DONE SHALL persist until out_ready=1, then the FSM SHALL return to IDLE on that edge.
REQ-014 in_valid SHALL be ignored while busy; operand inputs SHALL NOT affect an operation in flight.
REQ-015 out_ready asserted outside DONE SHALL have no effect.
REQ-016 Throughput SHALL be one operation per N+2 cycles at best (accept, N chunks, handoff); there is no back-to-back accept in the DONE-to-IDLE cycle.

Reset
REQ-017 rst_n=0 SHALL immediately force: state IDLE, counter 0, carry 0, val_e 0, err 0, out_valid 0, in_ready 1, busy 0, cc=3'b100.
REQ-018 Reset asserted during CALC or DONE SHALL abort the operation with no cc update and no out_valid pulse.

Verification
REQ-019 addq, val_a=1, val_b=2, set_cc=1 -> out_valid 4 cycles after accept, val_e=3, cc=000.
REQ-020 subq, val_a=val_b=5, set_cc=1 -> val_e=0, cc=100.
REQ-021 addq, val_a=1, val_b=0x7FFF_FFFF_FFFF_FFFF -> val_e=0x8000_0000_0000_0000, cc=011; the same operation with set_cc=0 -> cc unchanged.
REQ-022 addq, val_a=0x0000_0000_0000_FFFF, val_b=1 -> val_e=0x1_0000 (carry crosses the chunk boundary), cc=000; subq, val_a=1, val_b=0 -> val_e=all ones, cc=010.
REQ-023 ifun=4 -> err=1, val_e=0, cc unchanged, out_valid after 1 cycle; out_ready held 0 for 3 cycles -> outputs stable, in_ready=0, new in_valid ignored.
REQ-024 rst_n pulsed low in cycle 2 of CALC -> out_valid never asserts, cc=100, in_ready=1; the next addq 2+3 -> val_e=5.

Source files
------------

// File: rtl/alu_cc_sequencer.sv
// Multi-cycle Y86 OPq unit: pushes a 64-bit add/sub/and/xor through one shared
// CHUNK_W-bit slice, lowest chunk first, and updates ZF/SF/OF at completion.
module alu_cc_sequencer #(
   parameter int CHUNK_W = 16
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [3:0]  ifun,
   input  logic [63:0] val_a,
   input  logic [63:0] val_b,
   input  logic        set_cc,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [63:0] val_e,
   output logic [2:0]  cc,
   output logic        err,
   output logic        busy
);
   localparam int N  = 64 / CHUNK_W;
   localparam int CW = (N > 1) ? $clog2(N) : 1;

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

   state_t        state_q;
   logic [1:0]    op_q;
   logic [63:0]   a_q, b_q;
   logic          set_cc_q;
   logic [CW-1:0] cnt_q;
   logic          carry_q;
   logic          nz_q;
   logic [63:0]   val_e_q;
   logic          err_q;
   logic [2:0]    cc_q;

   logic [CHUNK_W-1:0] a_chunk [N];
   logic [CHUNK_W-1:0] b_chunk [N];

   generate
      for (genvar gi = 0; gi < N; gi++) begin : g_slice
         assign a_chunk[gi] = a_q[gi*CHUNK_W +: CHUNK_W];
         assign b_chunk[gi] = b_q[gi*CHUNK_W +: CHUNK_W];
      end
   endgenerate

   logic [CHUNK_W-1:0] a_sel, b_sel, a_eff, res_d;
   logic [CHUNK_W:0]   sum_d;
   logic               is_sub, cin, last, of_d, zf_d;
   logic [2:0]         cc_d;

   always_comb begin
      a_sel  = a_chunk[cnt_q];
      b_sel  = b_chunk[cnt_q];
      is_sub = (op_q == 2'd1);
      a_eff  = is_sub ? ~a_sel : a_sel;
      // Subtraction injects its +1 at chunk 0; later chunks take the registered carry.
      cin    = (cnt_q == '0) ? is_sub : carry_q;
      sum_d  = {1'b0, b_sel} + {1'b0, a_eff} + {{CHUNK_W{1'b0}}, cin};
      case (op_q)
         2'd2:    res_d = b_sel & a_sel;
         2'd3:    res_d = b_sel ^ a_sel;
         default: res_d = sum_d[CHUNK_W-1:0];
      endcase
      last = (cnt_q == CW'(N - 1));
      case (op_q)
         2'd0:    of_d = (a_q[63] == b_q[63]) && (res_d[CHUNK_W-1] != a_q[63]);
         2'd1:    of_d = (a_q[63] != b_q[63]) && (res_d[CHUNK_W-1] != b_q[63]);
         default: of_d = 1'b0;
      endcase
      zf_d = !(nz_q || (|res_d));
      cc_d = {zf_d, res_d[CHUNK_W-1], of_d};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         op_q     <= 2'd0;
         a_q      <= '0;
         b_q      <= '0;
         set_cc_q <= 1'b0;
         cnt_q    <= '0;
         carry_q  <= 1'b0;
         nz_q     <= 1'b0;
         val_e_q  <= '0;
         err_q    <= 1'b0;
         cc_q     <= 3'b100;
      end else begin
         case (state_q)
            IDLE: begin
               if (in_valid) begin
                  op_q     <= ifun[1:0];
                  a_q      <= val_a;
                  b_q      <= val_b;
                  set_cc_q <= set_cc;
                  cnt_q    <= '0;
                  carry_q  <= 1'b0;
                  nz_q     <= 1'b0;
                  val_e_q  <= '0;
                  err_q    <= |ifun[3:2];
                  state_q  <= (|ifun[3:2]) ? DONE : CALC;
               end
            end
            CALC: begin
               for (int k = 0; k < N; k++) begin
                  if (cnt_q == CW'(k)) val_e_q[k*CHUNK_W +: CHUNK_W] <= res_d;
               end
               carry_q <= sum_d[CHUNK_W];
               nz_q    <= nz_q | (|res_d);
               cnt_q   <= cnt_q + 1'b1;
               if (last) begin
                  state_q <= DONE;
                  if (set_cc_q) cc_q <= cc_d;
               end
            end
            DONE: begin
               if (out_ready) state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign in_ready  = (state_q == IDLE);
   assign out_valid = (state_q == DONE);
   assign busy      = (state_q != IDLE);
   assign val_e     = val_e_q;
   assign err       = err_q;
   assign cc        = cc_q;
endmodule

// File: tb/tb_alu_cc_sequencer.sv
// Scoreboard bench for alu_cc_sequencer: a driver queues expected results,
// a negedge monitor compares them at each output handshake.
module tb_alu_cc_sequencer;
   localparam int N = 4;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid, in_ready;
   logic [3:0]  ifun;
   logic [63:0] val_a, val_b;
   logic        set_cc;
   logic        out_valid, out_ready;
   logic [63:0] val_e;
   logic [2:0]  cc;
   logic        err, busy;

   always #5 clk = ~clk;

   alu_cc_sequencer #(.CHUNK_W(16)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .ifun(ifun), .val_a(val_a), .val_b(val_b), .set_cc(set_cc),
      .out_valid(out_valid), .out_ready(out_ready), .val_e(val_e),
      .cc(cc), .err(err), .busy(busy)
   );

   typedef struct {
      logic [63:0] v;
      logic [2:0]  cc;
      logic        err;
      int          lat;
      string       name;
   } exp_t;

   exp_t exp_q[$];
   int   acc_q[$];
   int   tests = 0;
   int   fails = 0;
   int   cyc = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      tests++;
      if (act !== req) begin
         fails++;
         $display("FAIL %s: got %h, required %h", name, act, req);
      end
   endtask

   // Monitor: measure out_valid latency at its rise, compare at handshake.
   initial begin
      logic prev_ov;
      int   cur_lat;
      exp_t e;
      prev_ov = 1'b0;
      cur_lat = -1;
      forever begin
         @(negedge clk);
         if (out_valid && !prev_ov) begin
            if (acc_q.size() > 0) cur_lat = cyc - acc_q.pop_front();
            else cur_lat = -1;
         end
         prev_ov = out_valid;
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               tests++;
               fails++;
               $display("FAIL unexpected_output: got val_e %h, required no output", val_e);
            end else begin
               e = exp_q.pop_front();
               check({e.name, "_val_e"}, val_e, e.v);
               check({e.name, "_cc"}, 64'(cc), 64'(e.cc));
               check({e.name, "_err"}, 64'(err), 64'(e.err));
               check({e.name, "_latency"}, 64'(cur_lat), 64'(e.lat));
               $display("[TB] %s: val_e=%h cc=%b err=%b latency=%0d", e.name, val_e, cc, err, cur_lat);
            end
         end
      end
   end

   task automatic issue(input logic [3:0] f, input logic [63:0] a, input logic [63:0] b,
                        input logic sc, input logic [63:0] ev, input logic [2:0] ecc,
                        input logic eerr, input string nm, input bit track);
      int   n;
      exp_t e;
      n = 0;
      while (!in_ready && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      if (!in_ready) begin
         tests++;
         fails++;
         $display("FAIL %s_accept_timeout: in_ready 0, required 1", nm);
         return;
      end
      ifun = f; val_a = a; val_b = b; set_cc = sc; in_valid = 1'b1;
      if (track) begin
         e.v = ev; e.cc = ecc; e.err = eerr; e.lat = (f > 4'd3) ? 0 : N; e.name = nm;
         exp_q.push_back(e);
      end
      @(posedge clk); #1;
      if (track) acc_q.push_back(cyc);
      // Scramble operands so anything sampled after accept would corrupt the result.
      in_valid = 1'b0;
      val_a = ~a;
      val_b = ~b ^ 64'h5A;
      ifun = f ^ 4'h1;
      set_cc = ~sc;
   endtask

   initial begin
      int n;
      #200000;
      $display("FAIL watchdog: simulation time exceeded, required completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      rst_n = 1'b0; in_valid = 1'b0; ifun = 4'd0; val_a = '0; val_b = '0;
      set_cc = 1'b0; out_ready = 1'b1;
      #12;
      check("reset_in_ready", 64'(in_ready), 64'd1);
      check("reset_out_valid", 64'(out_valid), 64'd0);
      check("reset_busy", 64'(busy), 64'd0);
      check("reset_cc", 64'(cc), 64'(3'b100));
      check("reset_val_e", val_e, 64'd0);
      check("reset_err", 64'(err), 64'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;

      issue(4'd0, 64'd1, 64'd2, 1'b1, 64'd3, 3'b000, 1'b0, "add_1_2", 1'b1);
      issue(4'd1, 64'd5, 64'd5, 1'b1, 64'd0, 3'b100, 1'b0, "sub_5_5", 1'b1);
      issue(4'd0, 64'd1, 64'h7FFF_FFFF_FFFF_FFFF, 1'b0, 64'h8000_0000_0000_0000, 3'b100, 1'b0, "add_ovf_nocc", 1'b1);
      issue(4'd0, 64'd1, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 64'h8000_0000_0000_0000, 3'b011, 1'b0, "add_ovf", 1'b1);
      issue(4'd0, 64'h0000_0000_0000_FFFF, 64'd1, 1'b1, 64'h0000_0000_0001_0000, 3'b000, 1'b0, "add_carry_chunk", 1'b1);
      issue(4'd1, 64'd1, 64'd0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 3'b010, 1'b0, "sub_0_1", 1'b1);
      issue(4'd0, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 64'd0, 3'b100, 1'b0, "add_wrap", 1'b1);
      issue(4'd2, 64'hF0F0_F0F0_F0F0_F0F0, 64'hFF00_FF00_FF00_FF00, 1'b1, 64'hF000_F000_F000_F000, 3'b010, 1'b0, "and", 1'b1);
      issue(4'd3, 64'hF0F0_F0F0_F0F0_F0F0, 64'hFF00_FF00_FF00_FF00, 1'b1, 64'h0FF0_0FF0_0FF0_0FF0, 3'b000, 1'b0, "xor", 1'b1);
      issue(4'd2, 64'hFF00_FF00_FF00_FF00, 64'h00FF_00FF_00FF_00FF, 1'b1, 64'd0, 3'b100, 1'b0, "and_zero", 1'b1);
      issue(4'd1, 64'd1, 64'h8000_0000_0000_0000, 1'b1, 64'h7FFF_FFFF_FFFF_FFFF, 3'b001, 1'b0, "sub_ovf", 1'b1);
      issue(4'd0, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b1, 64'd0, 3'b101, 1'b0, "add_neg_ovf", 1'b1);

      // Illegal function with the consumer stalled: outputs must hold and requests be ignored.
      n = 0;
      while (!in_ready && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      out_ready = 1'b0;
      issue(4'd4, 64'd9, 64'd9, 1'b1, 64'd0, 3'b101, 1'b1, "illegal", 1'b1);
      for (int i = 0; i < 3; i++) begin
         check("hold_out_valid", 64'(out_valid), 64'd1);
         check("hold_in_ready", 64'(in_ready), 64'd0);
         check("hold_val_e", val_e, 64'd0);
         check("hold_err", 64'(err), 64'd1);
         check("hold_cc", 64'(cc), 64'(3'b101));
         ifun = 4'd0; val_a = 64'd1; val_b = 64'd1; set_cc = 1'b1; in_valid = 1'b1;
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      @(posedge clk); #1;

      // Abort an add in its second CALC cycle.
      issue(4'd0, 64'd7, 64'd9, 1'b1, 64'd0, 3'b000, 1'b0, "aborted", 1'b0);
      @(posedge clk); #1;
      rst_n = 1'b0;
      #1;
      check("abort_in_ready", 64'(in_ready), 64'd1);
      check("abort_out_valid", 64'(out_valid), 64'd0);
      check("abort_busy", 64'(busy), 64'd0);
      check("abort_cc", 64'(cc), 64'(3'b100));
      check("abort_val_e", val_e, 64'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      issue(4'd0, 64'd2, 64'd3, 1'b1, 64'd5, 3'b000, 1'b0, "add_after_reset", 1'b1);

      n = 0;
      while ((exp_q.size() > 0 || !in_ready) && n < 100) begin
         @(posedge clk); #1;
         n++;
      end
      check("scoreboard_drained", 64'(exp_q.size()), 64'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
